score_uart_tx: RTL
==================

# score_uart_tx

Serial transmitter that reports the game score to the host PC over UART. It is the outbound counterpart of the UART receiver that produces `uart_start`. On a one-cycle request from the game control FSM it latches a 12-bit score. It then sends a fixed six-byte ASCII frame: 'S', three uppercase hex digits, CR, LF. Each byte is sent as 8N1 on `txd`. It sits in the `pclk` domain next to the top-level state machine and drives the board's UART TX pin.

## Interface
- `CLKS_PER_BIT`, default 4167: `pclk` cycles per UART bit (40 MHz / 9600 baud). Legal range is at least 2.
- `pclk`  in  1  pixel/system clock (40 MHz); all state updates on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low. `rst`=0 forces reset state immediately.
- `score`  in  12  score value; sampled only on the cycle a request is accepted.
- `send_req`  in  1  one-cycle request strobe from the game FSM (SCORE state entry).
- `txd`  out  1  UART serial output, registered, idle high.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse when the final stop bit of the frame has completed.

## Operation
- Reset values: `txd`=1, `busy`=0, `done`=0. Internal FSM is IDLE; all counters and the score latch are 0.
- Request acceptance: `send_req`=1 while `busy`=0 is accepted. `score` is latched and the byte index is set to 0. `send_req` while `busy`=1 is ignored and not queued.
- Frame content, byte index 0..5:
  - 0x53 ('S').
  - hex(`score[11:8]`).
  - hex(`score[7:4]`).
  - hex(`score[3:0]`).
  - 0x0D.
  - 0x0A.
- Hex conversion: nibble 0–9 maps to 0x30+n; nibble 10–15 maps to 0x41+(n−10), i.e. uppercase 'A'–'F'.
- Byte format: one start bit (0), then 8 data bits LSB first, then one stop bit (1). That is 10 bit-times per byte.
- FSM states:
  - IDLE: `txd`=1. On acceptance go to START.
  - START: `txd`=0 for one bit-time, then go to DATA with bit counter 0.
  - DATA: `txd`=byte[bit] for one bit-time per bit. After bit 7 go to STOP.
  - STOP: `txd`=1 for one bit-time. Then, if byte index < 5, increment the index and go to START. If the index is 5, go to IDLE with `done` pulsed.
- There is no idle gap between bytes within a frame. The next start bit follows the stop bit directly.
- Baud counter: counts 0..CLKS_PER_BIT−1 and wraps. A bit boundary occurs at wrap. Its width is clog2(CLKS_PER_BIT).
- Bit counter: 3 bits, range 0..7. Byte index: 3 bits, range 0..5. Byte index never exceeds 5.
- Reset mid-frame: the frame is abandoned and `txd` returns high asynchronously. `done` is not pulsed and no partial retransmission occurs after reset release.
- The latched score is stable for the whole frame; changes on `score` during `busy` have no effect.

## Timing
- Request accepted at edge E:
  - At E, `busy`=1 and `txd`=0; the start bit of byte 0 begins.
  - Each bit of every byte holds for exactly CLKS_PER_BIT cycles.
- Frame duration: 60·CLKS_PER_BIT cycles from edge E.
- At edge E+60·CLKS_PER_BIT:
  - `busy`=0.
  - `done`=1 for exactly one cycle.
  - `txd`=1 (idle).
- In that `done` cycle `busy` is already 0. A `send_req` sampled on that cycle is accepted, and the next frame's start bit begins at the following edge.
- Latency from `send_req` to the first `txd` falling edge: the same edge that samples the request. There is zero added idle time.
- `done` and `busy` are registered outputs with no combinational path from inputs.

## Test plan
Use CLKS_PER_BIT=16 unless stated.
- `score`=12'h1A3, one `send_req` pulse:
  - `txd` decodes to 0x53, 0x31, 0x41, 0x33, 0x0D, 0x0A.
  - `busy` is high for exactly 960 cycles.
  - `done` pulses once, at cycle 960.
- Boundary values:
  - `score`=12'h000 gives "S000\r\n".
  - `score`=12'hFFF gives "SFFF\r\n".
  - `score`=12'h9AF gives "S9AF\r\n", checking the 9/A digit boundary.
- Ignored request and stable latch:
  - Pulse `send_req` at cycles 100 and 500 of a frame, with `score` changed to 12'h555 between them.
  - Required: exactly one frame, carrying the originally latched score, with a single `done`.
- Back-to-back frames:
  - Assert `send_req` in the `done` cycle with a new score 12'h2B0.
  - Required: the second frame's start bit begins on the next edge, with no extra idle bits, and the payload decodes to "S2B0\r\n".
- Async reset:
  - Drive `rst`=0 mid-DATA of byte 2.
  - Required: `txd`=1 and `busy`=0 before the next `pclk` edge, and no `done`.
  - After release, `txd` stays high until a new `send_req`.
- Bit timing with CLKS_PER_BIT=4167:
  - Measure the start-bit width and the first data-bit width; each must be exactly 4167 cycles.
  - Total `busy` time must be 250020 cycles.

Source files
------------

// File: rtl/score_uart_tx_if.sv
// Score-report handshake between the game FSM (master) and the UART transmitter (slave).
interface score_uart_tx_if;
    logic [11:0] score;
    logic        send_req;
    logic        txd;
    logic        busy;
    logic        done;

    modport master (output score, output send_req, input txd, input busy, input done);
    modport slave  (input score, input send_req, output txd, output busy, output done);
endinterface

// File: rtl/score_uart_tx.sv
// Sends "S<hex><hex><hex>\r\n" as 8N1 UART for a latched 12-bit score.
module score_uart_tx #(
    parameter int CLKS_PER_BIT = 4167
) (
    input  logic          pclk,
    input  logic          rst,
    score_uart_tx_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_idx;
    logic [11:0]   score_q;
    logic          txd_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    cur_byte;
    logic          wrap;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        cur_byte = 8'h53;
        case (byte_idx)
            3'd0:    cur_byte = 8'h53;
            3'd1:    cur_byte = hex_ascii(score_q[11:8]);
            3'd2:    cur_byte = hex_ascii(score_q[7:4]);
            3'd3:    cur_byte = hex_ascii(score_q[3:0]);
            3'd4:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign wrap = (baud_cnt == BAUD_MAX);

    // txd is updated on the edge that starts each bit, so the line is fully registered
    // and the start bit appears on the same edge that accepts the request.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            score_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == S_IDLE) begin
                txd_q <= 1'b1;
                if (bus.send_req) begin
                    state    <= S_START;
                    score_q  <= bus.score;
                    byte_idx <= '0;
                    bit_cnt  <= '0;
                    baud_cnt <= '0;
                    busy_q   <= 1'b1;
                    txd_q    <= 1'b0;
                end
            end else begin
                baud_cnt <= wrap ? '0 : baud_cnt + 1'b1;
                if (wrap) begin
                    case (state)
                        S_START: begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                            txd_q   <= cur_byte[0];
                        end
                        S_DATA: begin
                            if (bit_cnt == 3'd7) begin
                                state <= S_STOP;
                                txd_q <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                txd_q   <= cur_byte[bit_cnt + 3'd1];
                            end
                        end
                        default: begin
                            if (byte_idx < 3'd5) begin
                                byte_idx <= byte_idx + 3'd1;
                                state    <= S_START;
                                txd_q    <= 1'b0;
                            end else begin
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                txd_q  <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
